// File: rtl/msg_streamer.sv
// Character-stream source: loadable DEPTH-entry buffer played out over valid/ready.
// Optional build macro MSG_STREAMER_DIV_EN adds inter-character pacing (WAIT state).
module msg_streamer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = 6,
   parameter int DIV_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [IDX_W:0]    len_i,
   input  logic              loop_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic              start_i,
   input  logic              stop_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_last_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int LW = IDX_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_DONE    = 2'd2
`ifdef MSG_STREAMER_DIV_EN
      , ST_WAIT  = 2'd3
`endif
   } state_t;

   logic [DATA_W-1:0] buf_q [DEPTH];
   state_t            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LW-1:0]     len_q;
   logic              loop_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              busy_q;
   logic              done_q;

`ifdef MSG_STREAMER_DIV_EN
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  cnt_q;
`else
   logic              div_unused_s;
   assign div_unused_s = ^div_i;
`endif

   logic [LW-1:0]     len_d;
   logic [IDX_W-1:0]  idx_d;
   logic              xfer_s;
   logic              final_s;
   logic              next_last_s;

   // Buffer write port; out-of-range addresses are dropped
   always_ff @(posedge clk_i) begin
      if (wr_en_i && (LW'(wr_addr_i) < LW'(DEPTH))) begin
         buf_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Length clamp, transfer detect and next-index computation
   always_comb begin
      len_d       = {LW{1'b0}};
      idx_d       = {IDX_W{1'b0}};
      xfer_s      = out_valid_q && out_ready_i;
      final_s     = ((LW'(idx_q) + LW'(1)) == len_q);
      next_last_s = 1'b0;
      if (len_i > LW'(DEPTH)) begin
         len_d = LW'(DEPTH);
      end else begin
         len_d = len_i;
      end
      if (final_s) begin
         idx_d = {IDX_W{1'b0}};
      end else begin
         idx_d = idx_q + IDX_W'(1);
      end
      next_last_s = ((LW'(idx_d) + LW'(1)) == len_q);
   end

   // Playback FSM with registered outputs; stop outranks start and transfers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         idx_q       <= {IDX_W{1'b0}};
         len_q       <= {LW{1'b0}};
         loop_q      <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef MSG_STREAMER_DIV_EN
         div_q       <= {DIV_W{1'b0}};
         cnt_q       <= {DIV_W{1'b0}};
`endif
      end else if (stop_i) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i && (len_i != {LW{1'b0}})) begin
                  len_q       <= len_d;
                  loop_q      <= loop_i;
`ifdef MSG_STREAMER_DIV_EN
                  div_q       <= div_i;
`endif
                  idx_q       <= {IDX_W{1'b0}};
                  out_data_q  <= buf_q[0];
                  out_last_q  <= (len_d == LW'(1));
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  state_q     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (xfer_s) begin
                  if (final_s && !loop_q) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
`ifdef MSG_STREAMER_DIV_EN
                  end else if (div_q != {DIV_W{1'b0}}) begin
                     idx_q       <= idx_d;
                     cnt_q       <= div_q;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     state_q     <= ST_WAIT;
`endif
                  end else begin
                     idx_q      <= idx_d;
                     out_data_q <= buf_q[idx_d];
                     out_last_q <= next_last_s;
                  end
               end
            end
`ifdef MSG_STREAMER_DIV_EN
            // idx_q already points at the next character here
            ST_WAIT: begin
               if (cnt_q == DIV_W'(1)) begin
                  cnt_q       <= {DIV_W{1'b0}};
                  out_data_q  <= buf_q[idx_q];
                  out_last_q  <= final_s;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_PRESENT;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
`endif
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_msg_streamer.sv
// Scoreboard bench for msg_streamer; expected characters are queued at start and
// popped on every observed transfer, with inter-transfer gap checks.
module tb_msg_streamer;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int IDX_W  = 6;
   localparam int DIV_W  = 16;
`ifdef MSG_STREAMER_DIV_EN
   localparam int PACE = 2;
`else
   localparam int PACE = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [IDX_W-1:0]  wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [IDX_W:0]    len = '0;
   logic              loop = 1'b0;
   logic [DIV_W-1:0]  div = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              out_last;
   logic              busy;
   logic              done;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   msg_streamer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .DIV_W(DIV_W)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .len_i      (len),
      .loop_i     (loop),
      .div_i      (div),
      .start_i    (start),
      .stop_i     (stop),
      .out_data_o (out_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_last_o (out_last),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [7:0] d, input logic l, input int g);
      exp_t e;
      e.data = d;
      e.last = l;
      e.gap  = g;
      sb.push_back(e);
   endtask

   task automatic write_buf(input int a, input logic [7:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = IDX_W'(a);
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start(input int l, input logic lp, input int d);
      @(negedge clk);
      len   = (IDX_W+1)'(l);
      loop  = lp;
      div   = DIV_W'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Pops and checks one expected entry per observed transfer; stops at the
   // negedge just before the final expected transfer's clock edge.
   task automatic run_stream(input int budget);
      int   last_cyc;
      exp_t e;
      last_cyc = -1;
      for (int i = 0; i < budget && sb.size() > 0; i++) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if (out_data !== e.data || out_last !== e.last) begin
               errors++;
               $display("FAIL stream_char got %h/last=%b expected %h/last=%b", out_data, out_last, e.data, e.last);
            end
            if (e.gap > 0 && last_cyc >= 0) begin
               checks++;
               if ((cyc - last_cyc) !== e.gap) begin
                  errors++;
                  $display("FAIL stream_gap char %h got %0d cycles expected %0d", e.data, cyc - last_cyc, e.gap);
               end
            end
            last_cyc = cyc;
         end
         if (sb.size() > 0) @(negedge clk);
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL stream_timeout got %0d characters missing expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_data, out_valid, out_last, busy, done} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state got %h expected 000", {out_data, out_valid, out_last, busy, done});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_oneshot();
      write_buf(0, 8'h48);
      write_buf(1, 8'h6F);
      write_buf(2, 8'h6C);
      write_buf(3, 8'h61);
      out_ready = 1'b1;
      pulse_start(4, 1'b0, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h48 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_latency got v=%b d=%h busy=%b expected v=1 d=48 busy=1", out_valid, out_data, busy);
      end
      push(8'h48, 1'b0, 0);
      push(8'h6F, 1'b0, 1);
      push(8'h6C, 1'b0, 1);
      push(8'h61, 1'b1, 1);
      run_stream(20);
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== 3'b010) begin
         errors++;
         $display("FAIL oneshot_done got busy/done/valid=%b expected 010", {busy, done, out_valid});
      end
   endtask

   task automatic test_loop_pacing();
      pulse_start(4, 1'b1, 2);
      push(8'h48, 1'b0, 0);
      push(8'h6F, 1'b0, PACE + 1);
      push(8'h6C, 1'b0, PACE + 1);
      push(8'h61, 1'b1, PACE + 1);
      push(8'h48, 1'b0, PACE + 1);
      push(8'h6F, 1'b0, PACE + 1);
      run_stream(80);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({busy, done, out_valid, out_last} !== 4'b0000) begin
         errors++;
         $display("FAIL loop_stop got busy/done/valid/last=%b expected 0000", {busy, done, out_valid, out_last});
      end
   endtask

   task automatic test_backpressure();
      pulse_start(4, 1'b0, 0);
      checks++;
      if (out_data !== 8'h48 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_first got %h expected 48", out_data);
      end
      @(negedge clk);
      out_ready = 1'b0;
      wr_en     = 1'b1;
      wr_addr   = 6'd1;
      wr_data   = 8'h00;
      checks++;
      if (out_data !== 8'h6F || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_second got %h expected 6f", out_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr_en = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h6F) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%h expected v=1 d=6f", out_valid, out_data);
         end
      end
      out_ready = 1'b1;
      push(8'h6F, 1'b0, 0);
      push(8'h6C, 1'b0, 1);
      push(8'h61, 1'b1, 1);
      run_stream(20);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_done got done=%b busy=%b expected 1 0", done, busy);
      end
      write_buf(1, 8'h6F);
   endtask

   task automatic test_abort();
      pulse_start(4, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (out_data !== 8'h6C || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre got %h expected 6c", out_data);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle got valid/busy/done=%b expected 000", {out_valid, busy, done});
      end
      pulse_start(4, 1'b0, 0);
      checks++;
      if (out_data !== 8'h48 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_restart got %h expected 48", out_data);
      end
      push(8'h48, 1'b0, 0);
      push(8'h6F, 1'b0, 1);
      push(8'h6C, 1'b0, 1);
      push(8'h61, 1'b1, 1);
      run_stream(20);
      @(negedge clk);
   endtask

   task automatic test_len_edges();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      pulse_start(0, 1'b0, 0);
      @(negedge clk);
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL len0_ignored got valid/busy/done=%b expected 000", {out_valid, busy, done});
      end
      for (int i = 0; i < DEPTH; i++) write_buf(i, 8'(i * 3 + 1));
      pulse_start(100, 1'b0, 0);
      for (int i = 0; i < DEPTH; i++) push(8'(i * 3 + 1), (i == DEPTH - 1), (i == 0) ? 0 : 1);
      run_stream(200);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL len_clamp_done got done=%b busy=%b valid=%b expected 1 0 0", done, busy, out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      pulse_start(4, 1'b1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({out_data, out_valid, out_last, busy, done} !== 12'h000) begin
         errors++;
         $display("FAIL midreset_state got %h expected 000", {out_data, out_valid, out_last, busy, done});
      end
      pulse_start(3, 1'b0, 0);
      push(8'h01, 1'b0, 0);
      push(8'h04, 1'b0, 1);
      push(8'h07, 1'b1, 1);
      run_stream(20);
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL midreset_done got %b expected 1", done);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_loop_pacing();
      test_backpressure();
      test_abort();
      test_len_edges();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
